// File: rtl/tdm_demux4_pkg.sv
// Shared TDM link definitions: channel count, slot index width and FSM state codes.
package tdm_demux4_pkg;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux4_slot_timer.sv
// Cycle-within-slot and slot-within-frame counters for the TDM receiver.
module tdm_demux4_slot_timer
  import tdm_demux4_pkg::*;
#(
  parameter int unsigned SLOT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_sample_tick_c,
  output logic              o_frame_end_c,
  output logic              o_at_frame_start_c
);

  localparam int unsigned     CYC_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYC - 1);

  logic [CYC_W-1:0]  r_cyc;
  logic [SLOT_W-1:0] r_slot;

  assign o_slot             = r_slot;
  assign o_sample_tick_c    = (r_cyc == CYC_LAST);
  assign o_frame_end_c      = o_sample_tick_c && (r_slot == SLOT_W'(N_CH - 1));
  assign o_at_frame_start_c = (r_cyc == '0) && (r_slot == '0);

  // Counters advance while running and collapse to frame start otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc  <= '0;
      r_slot <= '0;
    end else if (!i_run) begin
      r_cyc  <= '0;
      r_slot <= '0;
    end else if (o_sample_tick_c) begin
      r_cyc  <= '0;
      r_slot <= r_slot + SLOT_W'(1);
    end else begin
      r_cyc  <= r_cyc + CYC_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM receiver: frame-sync hunt, flywheel lock and parallel frame output.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int unsigned SLOT_CYC = 1,
  parameter int unsigned MISS_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              fsync,
  output logic [N_CH-1:0]   q,
  output logic              q_valid,
  output logic              locked,
  output logic              sync_err,
  output logic [SLOT_W-1:0] slot
);

  localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [MISS_W-1:0] r_miss;
  logic [MISS_W-1:0] w_miss_inc;
  logic [N_CH-2:0]   r_shadow;
  logic [SLOT_W-1:0] w_slot;
  logic              w_sample_tick;
  logic              w_frame_end;
  logic              w_at_start;
  logic              w_fault;
  logic              w_drop;
  logic              w_run;
  logic              w_sample;
  logic              w_deliver;

  tdm_demux4_slot_timer #(
    .SLOT_CYC (SLOT_CYC)
  ) u_timer (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_run              (w_run),
    .o_slot             (w_slot),
    .o_sample_tick_c    (w_sample_tick),
    .o_frame_end_c      (w_frame_end),
    .o_at_frame_start_c (w_at_start)
  );

  assign slot       = w_slot;
  assign w_miss_inc = r_miss + MISS_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_HUNT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT: if (fsync)  w_state_nxt = ST_LOCK;
      ST_LOCK: if (w_drop) w_state_nxt = ST_HUNT;
      default:             w_state_nxt = ST_HUNT;
    endcase
  end

  // A sync fault is fsync present off frame start, or absent at frame start.
  always_comb begin
    w_fault   = 1'b0;
    w_drop    = 1'b0;
    w_run     = 1'b0;
    w_sample  = 1'b0;
    w_deliver = 1'b0;
    if (r_state == ST_LOCK) begin
      w_fault = w_at_start ^ fsync;
      w_drop  = w_fault && (w_miss_inc == MISS_W'(MISS_MAX));
      w_run   = !w_drop;
    end else begin
      w_run   = fsync;
    end
    w_sample  = w_run && w_sample_tick;
    w_deliver = w_sample && w_frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss   <= '0;
      r_shadow <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      q_valid  <= w_deliver;
      sync_err <= w_fault;
      locked   <= (w_state_nxt == ST_LOCK);
      if (r_state == ST_HUNT || w_drop) begin
        r_miss <= '0;
      end else if (w_fault) begin
        r_miss <= w_miss_inc;
      end else if (w_at_start) begin
        r_miss <= '0;
      end
      if (!w_run) begin
        r_shadow <= '0;
      end else begin
        for (int unsigned i = 0; i < N_CH - 1; i++) begin
          if (w_sample && (w_slot == SLOT_W'(i))) r_shadow[i] <= din;
        end
      end
      if (w_deliver) q <= {din, r_shadow};
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 at SLOT_CYC=1 (dut 0) and SLOT_CYC=7 (dut 1).
module tb_tdm_demux4;

  localparam int unsigned MISS_MAX = 2;

  logic       clk;
  logic       rst_n;
  logic       din_v   [2];
  logic       fsync_v [2];
  logic [3:0] q_v     [2];
  logic       qv_v    [2];
  logic       lk_v    [2];
  logic       err_v   [2];
  logic [1:0] slot_v  [2];

  int errors = 0;
  int checks = 0;

  tdm_demux4 #(.SLOT_CYC(1), .MISS_MAX(MISS_MAX)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din_v[0]), .fsync(fsync_v[0]),
    .q(q_v[0]), .q_valid(qv_v[0]), .locked(lk_v[0]), .sync_err(err_v[0]),
    .slot(slot_v[0])
  );

  tdm_demux4 #(.SLOT_CYC(7), .MISS_MAX(MISS_MAX)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .din(din_v[1]), .fsync(fsync_v[1]),
    .q(q_v[1]), .q_valid(qv_v[1]), .locked(lk_v[1]), .sync_err(err_v[1]),
    .slot(slot_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the frame as a plain integer.
  int         m_pos  [2];
  int         m_miss [2];
  bit         m_lock [2];
  bit         m_qv   [2];
  bit         m_err  [2];
  logic [3:0] m_q    [2];
  logic [3:0] m_bits [2];

  function automatic int sc(input int k);
    return (k == 0) ? 1 : 7;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; m_miss[k] = 0; m_lock[k] = 0;
      m_qv[k] = 0; m_err[k] = 0; m_q[k] = 4'h0; m_bits[k] = 4'h0;
    end
  endtask

  task automatic model_advance(input int k, input bit d);
    int ch;
    if ((m_pos[k] % sc(k)) == sc(k) - 1) begin
      ch = m_pos[k] / sc(k);
      m_bits[k][ch] = d;
      if (ch == 3) begin
        m_q[k]  = m_bits[k];
        m_qv[k] = 1;
      end
    end
    m_pos[k] = (m_pos[k] + 1) % (4 * sc(k));
  endtask

  task automatic model_step(input int k, input bit d, input bit f);
    bit fault;
    bit drop;
    m_qv[k] = 0;
    m_err[k] = 0;
    if (!m_lock[k]) begin
      if (f) begin
        m_lock[k] = 1; m_miss[k] = 0; m_pos[k] = 0;
        model_advance(k, d);
      end
    end else begin
      fault = ((m_pos[k] == 0) != f);
      drop  = 0;
      if (fault) begin
        m_err[k] = 1;
        m_miss[k]++;
        drop = (m_miss[k] == MISS_MAX);
      end else if (m_pos[k] == 0) begin
        m_miss[k] = 0;
      end
      if (drop) begin
        m_lock[k] = 0; m_pos[k] = 0; m_miss[k] = 0; m_bits[k] = 4'h0;
      end else begin
        model_advance(k, d);
      end
    end
  endtask

  task automatic chk(input string n, input int k, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h want %0h", k, n, got, exp);
    end
  endtask

  task automatic check_dut(input int k);
    logic [1:0] es;
    es = m_lock[k] ? 2'(m_pos[k] / sc(k)) : 2'd0;
    chk("model_q",        k, {4'h0, q_v[k]},    {4'h0, m_q[k]});
    chk("model_q_valid",  k, {7'h0, qv_v[k]},   {7'h0, m_qv[k]});
    chk("model_locked",   k, {7'h0, lk_v[k]},   {7'h0, m_lock[k]});
    chk("model_sync_err", k, {7'h0, err_v[k]},  {7'h0, m_err[k]});
    chk("model_slot",     k, {6'h0, slot_v[k]}, {6'h0, es});
  endtask

  task automatic step(input int k, input bit d, input bit f);
    din_v[k] = d; fsync_v[k] = f;
    din_v[1-k] = 1'b0; fsync_v[1-k] = 1'b0;
    @(posedge clk);
    model_step(k, d, f);
    model_step(1 - k, 1'b0, 1'b0);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic send_frame(input int k, input logic [3:0] v, input bit sync);
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < sc(k); c++)
        step(k, v[s], sync && s == 0 && c == 0);
  endtask

  typedef struct {
    bit         d;
    bit         f;
    logic [3:0] q;
    bit         qv;
    bit         lk;
    bit         err;
    logic [1:0] slot;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit d, bit f, logic [3:0] q, bit qv, bit lk, bit err, logic [1:0] s);
    vec_t v;
    v.d = d; v.f = f; v.q = q; v.qv = qv; v.lk = lk; v.err = err; v.slot = s;
    tbl.push_back(v);
  endfunction

  initial begin
    bit saw_qv;
    int sp;

    // Single-frame decode then four walking-one frames at SLOT_CYC=1.
    add(1, 1, 4'b0000, 0, 1, 0, 1); add(0, 0, 4'b0000, 0, 1, 0, 2);
    add(1, 0, 4'b0000, 0, 1, 0, 3); add(1, 0, 4'b1101, 1, 1, 0, 0);
    add(1, 1, 4'b1101, 0, 1, 0, 1); add(0, 0, 4'b1101, 0, 1, 0, 2);
    add(0, 0, 4'b1101, 0, 1, 0, 3); add(0, 0, 4'b0001, 1, 1, 0, 0);
    add(0, 1, 4'b0001, 0, 1, 0, 1); add(1, 0, 4'b0001, 0, 1, 0, 2);
    add(0, 0, 4'b0001, 0, 1, 0, 3); add(0, 0, 4'b0010, 1, 1, 0, 0);
    add(0, 1, 4'b0010, 0, 1, 0, 1); add(0, 0, 4'b0010, 0, 1, 0, 2);
    add(1, 0, 4'b0010, 0, 1, 0, 3); add(0, 0, 4'b0100, 1, 1, 0, 0);
    add(0, 1, 4'b0100, 0, 1, 0, 1); add(0, 0, 4'b0100, 0, 1, 0, 2);
    add(0, 0, 4'b0100, 0, 1, 0, 3); add(1, 0, 4'b1000, 1, 1, 0, 0);

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin din_v[k] = 1'b0; fsync_v[k] = 1'b0; end
    model_reset();
    repeat (2) @(negedge clk);
    check_dut(0);
    check_dut(1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(0, tbl[i].d, tbl[i].f);
      chk("tbl_q",        0, {4'h0, q_v[0]},    {4'h0, tbl[i].q});
      chk("tbl_q_valid",  0, {7'h0, qv_v[0]},   {7'h0, tbl[i].qv});
      chk("tbl_locked",   0, {7'h0, lk_v[0]},   {7'h0, tbl[i].lk});
      chk("tbl_sync_err", 0, {7'h0, err_v[0]},  {7'h0, tbl[i].err});
      chk("tbl_slot",     0, {6'h0, slot_v[0]}, {6'h0, tbl[i].slot});
    end

    // Misplaced fsync in slot 2: one error pulse, lock and frame kept.
    step(0, 1, 1); step(0, 0, 0); step(0, 1, 1);
    chk("misplace_err", 0, {7'h0, err_v[0]}, 8'd1);
    chk("misplace_lk",  0, {7'h0, lk_v[0]},  8'd1);
    step(0, 0, 0);
    chk("misplace_err_pulse", 0, {7'h0, err_v[0]}, 8'd0);
    chk("misplace_qv", 0, {7'h0, qv_v[0]}, 8'd1);
    chk("misplace_q",  0, {4'h0, q_v[0]},  8'h05);
    send_frame(0, 4'b0110, 1'b1);
    chk("resync_q", 0, {4'h0, q_v[0]}, 8'h06);

    // Two omitted syncs: first tolerated, second drops lock.
    step(0, 1, 0);
    chk("omit1_err", 0, {7'h0, err_v[0]}, 8'd1);
    chk("omit1_lk",  0, {7'h0, lk_v[0]},  8'd1);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    chk("omit1_qv", 0, {7'h0, qv_v[0]}, 8'd1);
    chk("omit1_q",  0, {4'h0, q_v[0]},  8'h0f);
    step(0, 1, 0);
    chk("omit2_err", 0, {7'h0, err_v[0]}, 8'd1);
    chk("omit2_lk",  0, {7'h0, lk_v[0]},  8'd0);
    saw_qv = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 1'(i), 0);
      if (qv_v[0] === 1'b1) saw_qv = 1;
    end
    chk("lost_no_qv", 0, {7'h0, saw_qv}, 8'd0);
    chk("lost_q_hold", 0, {4'h0, q_v[0]}, 8'h0f);

    // Relock on a later fsync and decode the following frame.
    send_frame(0, 4'b1000, 1'b1);
    chk("relock_lk", 0, {7'h0, lk_v[0]}, 8'd1);
    chk("relock_q",  0, {4'h0, q_v[0]},  8'h08);
    send_frame(0, 4'b0011, 1'b1);
    chk("relock_q2", 0, {4'h0, q_v[0]}, 8'h03);

    // SLOT_CYC=7: inverted glitch at cyc 3 of every slot must be ignored.
    for (int fr = 0; fr < 2; fr++) begin
      logic [3:0] v;
      v = (fr == 0) ? 4'b1010 : 4'b0101;
      for (int s = 0; s < 4; s++)
        for (int c = 0; c < 7; c++)
          step(1, (c == 3) ? ~v[s] : v[s], s == 0 && c == 0);
      chk("glitch_qv", 1, {7'h0, qv_v[1]}, 8'd1);
      chk("glitch_q",  1, {4'h0, q_v[1]},  {4'h0, v});
    end

    // Randomized traffic with occasional sync faults on both instances.
    for (int k = 0; k < 2; k++) begin
      sp = $urandom_range(0, 4 * sc(k) - 1);
      for (int i = 0; i < 1500; i++) begin
        step(k, 1'($urandom), (sp == 0) ^ ($urandom_range(0, 19) == 0));
        sp = (sp + 1) % (4 * sc(k));
      end
    end

    // Asynchronous reset in the middle of slot 2.
    send_frame(0, 4'b1111, 1'b1);
    step(0, 1, 1); step(0, 1, 0);
    din_v[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q",        0, {4'h0, q_v[0]},    8'd0);
    chk("rst_q_valid",  0, {7'h0, qv_v[0]},   8'd0);
    chk("rst_locked",   0, {7'h0, lk_v[0]},   8'd0);
    chk("rst_sync_err", 0, {7'h0, err_v[0]},  8'd0);
    chk("rst_slot",     0, {6'h0, slot_v[0]}, 8'd0);
    model_reset();
    @(negedge clk);
    chk("rst_hold_qv", 0, {7'h0, qv_v[0]}, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    chk("post_rst_hunt", 0, {7'h0, lk_v[0]}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
